// File: rtl/bk_nibble_sequencer_if.sv
// Handshake bundle for bk_nibble_sequencer: request side (valid/ready, operands, carry-in),
// result side (valid/ready, sum) and busy. `BK_SEQ_SUB_EN adds the sub select.
interface bk_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   sum;
  logic         busy;
`ifdef BK_SEQ_SUB_EN
  logic         sub;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, busy
`ifdef BK_SEQ_SUB_EN
    , output sub
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, busy
`ifdef BK_SEQ_SUB_EN
    , input sub
`endif
  );
endinterface

// File: rtl/bk_nibble_sequencer.sv
// Wide adder that reuses one 4-bit Brent-Kung adder, one nibble per clock, LSB first.
// Ports: clk, rst (sync, active-high), bus (slave). Macro BK_SEQ_SUB_EN adds subtract mode.
module Bruent (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [4:0] Sum
);
  logic [3:0] g;
  logic [3:0] p;
  logic       g10;
  logic       p10;
  logic       g32;
  logic       p32;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Prefix tree: pair groups, then combine with the incoming carry.
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];

  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g10 | (p10 & Cin);
  assign c[3] = g[2] | (p[2] & c[2]);
  assign c[4] = g32 | (p32 & c[2]);

  assign Sum = {c[4], p ^ c[3:0]};
endmodule

module bk_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic rst,
  bk_nibble_sequencer_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   res;
  logic [W-1:0]   res_nx;
  logic           carry_r;
  logic [IW-1:0]  idx;
  logic [W:0]     sum_r;
  logic [IW+1:0]  base;
  logic [3:0]     add_a;
  logic [3:0]     add_b;
  logic [4:0]     add_s;
  logic           last;
  logic           in_ready;
  logic           out_valid;
  logic           busy;
`ifdef BK_SEQ_SUB_EN
  logic           sub_r;
`endif

  assign base = {idx, 2'b00};
  assign last = (idx == IW'(NIBBLES - 1));

  always_comb begin
    add_a = a_r[base +: 4];
    add_b = b_r[base +: 4];
`ifdef BK_SEQ_SUB_EN
    if (sub_r) add_b = ~add_b;
`endif
    res_nx = res;
    res_nx[base +: 4] = add_s[3:0];
  end

  Bruent u_add (
    .A   (add_a),
    .B   (add_b),
    .Cin (carry_r),
    .Sum (add_s)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      res     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum_r   <= '0;
`ifdef BK_SEQ_SUB_EN
      sub_r   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.in_valid) begin
        a_r <= bus.a;
        b_r <= bus.b;
        idx <= '0;
`ifdef BK_SEQ_SUB_EN
        sub_r   <= bus.sub;
        // Two's complement: invert B per nibble, seed carry with 1.
        carry_r <= bus.sub ? 1'b1 : bus.cin;
`else
        carry_r <= bus.cin;
`endif
      end else if (state == RUN) begin
        res     <= res_nx;
        carry_r <= add_s[4];
        if (last) sum_r <= {add_s[4], res_nx};
        else      idx   <= idx + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.sum       = sum_r;
endmodule

// File: tb/tb_bk_nibble_sequencer.sv
// Bench for bk_nibble_sequencer: NIBBLES=4 instance (directed, random, backpressure,
// reset, back-to-back) and NIBBLES=1 instance (exhaustive). Honors BK_SEQ_SUB_EN.
module tb_bk_nibble_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  bk_nibble_sequencer_if #(.NIBBLES(4)) i4 ();
  bk_nibble_sequencer_if #(.NIBBLES(1)) i1 ();

  bk_nibble_sequencer #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(i4));
  bk_nibble_sequencer #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] nb;
    nb = ~b;
    if (sub) return 17'(a) + 17'(nb) + 17'd1;
    return 17'(a) + 17'(b) + 17'(cin);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!i4.in_ready && g < 40) begin
      tick();
      g++;
    end
  endtask

  // One full transaction on the 4-nibble instance; returns sum and accept-to-valid edges.
  task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, output logic [16:0] s, output int lat);
    wait_idle();
    i4.a = a;
    i4.b = b;
    i4.cin = cin;
`ifdef BK_SEQ_SUB_EN
    i4.sub = sub;
`endif
    i4.in_valid  = 1'b1;
    i4.out_ready = 1'b0;
    tick();
    i4.in_valid = 1'b0;
    i4.a   = 16'($urandom);
    i4.b   = 16'($urandom);
    i4.cin = 1'($urandom);
`ifdef BK_SEQ_SUB_EN
    i4.sub = ~sub;
`endif
    lat = 0;
    while (!i4.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    s = i4.sum;
    i4.out_ready = 1'b1;
    tick();
    i4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (i4.in_ready !== 1'b1 || i4.out_valid !== 1'b0 || i4.busy !== 1'b0 || i4.sum !== 17'h0) begin
      fails++;
      $display("FAIL reset4: rdy=%b vld=%b busy=%b sum=%h, want 1 0 0 00000",
               i4.in_ready, i4.out_valid, i4.busy, i4.sum);
    end
    checks++;
    if (i1.in_ready !== 1'b1 || i1.out_valid !== 1'b0 || i1.busy !== 1'b0 || i1.sum !== 5'h0) begin
      fails++;
      $display("FAIL reset1: rdy=%b vld=%b busy=%b sum=%h, want 1 0 0 00",
               i1.in_ready, i1.out_valid, i1.busy, i1.sum);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [15:0] va [3] = '{16'hFFFF, 16'hFFFF, 16'h1234};
    logic [15:0] vb [3] = '{16'h0001, 16'h0000, 16'h4321};
    logic        vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [16:0] ve [3] = '{17'h10000, 17'h10000, 17'h05555};
    logic [16:0] s;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run4(va[i], vb[i], vc[i], 1'b0, s, lat);
      checks++;
      if (s !== ve[i] || lat != 4) begin
        fails++;
        $display("FAIL directed%0d: sum=%h lat=%0d, want %h lat=4", i, s, lat, ve[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [16:0] s;
    int          lat;
    for (int i = 0; i < 25; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      run4(a, b, c, 1'b0, s, lat);
      checks++;
      if (s !== model(a, b, c, 1'b0) || lat != 4) begin
        fails++;
        $display("FAIL random%0d: %h+%h+%b sum=%h lat=%0d, want %h lat=4",
                 i, a, b, c, s, lat, model(a, b, c, 1'b0));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp0;
    logic [16:0] exp1;
    int          lat;
    exp0 = model(16'hABCD, 16'h1111, 1'b1, 1'b0);
    exp1 = model(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
    wait_idle();
    i4.a = 16'hABCD;
    i4.b = 16'h1111;
    i4.cin = 1'b1;
`ifdef BK_SEQ_SUB_EN
    i4.sub = 1'b0;
`endif
    i4.in_valid  = 1'b1;
    i4.out_ready = 1'b0;
    tick();
    i4.a = 16'h0F0F;
    i4.b = 16'hF0F1;
    i4.cin = 1'b0;
    lat = 0;
    while (!i4.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 4) begin
      fails++;
      $display("FAIL bp_latency: lat=%0d, want 4", lat);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i4.out_valid !== 1'b1 || i4.in_ready !== 1'b0 || i4.sum !== exp0) begin
        fails++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h, want 1 0 %h",
                 i, i4.out_valid, i4.in_ready, i4.sum, exp0);
      end
      tick();
    end
    i4.out_ready = 1'b1;
    tick();
    i4.out_ready = 1'b0;
    checks++;
    if (i4.in_ready !== 1'b1 || i4.busy !== 1'b0 || i4.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_after_hs: rdy=%b busy=%b vld=%b, want 1 0 0",
               i4.in_ready, i4.busy, i4.out_valid);
    end
    tick();
    i4.in_valid = 1'b0;
    checks++;
    if (i4.busy !== 1'b1 || i4.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept: busy=%b rdy=%b, want 1 0", i4.busy, i4.in_ready);
    end
    lat = 0;
    while (!i4.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (i4.sum !== exp1 || lat != 4) begin
      fails++;
      $display("FAIL bp_second: sum=%h lat=%0d, want %h lat=4", i4.sum, lat, exp1);
    end
    i4.out_ready = 1'b1;
    tick();
    i4.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [16:0] s;
    int          lat;
    bit          seen = 1'b0;
    wait_idle();
    i4.a = 16'h8888;
    i4.b = 16'h7777;
    i4.cin = 1'b1;
`ifdef BK_SEQ_SUB_EN
    i4.sub = 1'b0;
`endif
    i4.in_valid  = 1'b1;
    i4.out_ready = 1'b1;
    tick();
    i4.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (i4.in_ready !== 1'b1 || i4.busy !== 1'b0 || i4.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: rdy=%b busy=%b vld=%b, want 1 0 0",
               i4.in_ready, i4.busy, i4.out_valid);
    end
    for (int i = 0; i < 8; i++) begin
      if (i4.out_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      fails++;
      $display("FAIL rst_abort: out_valid=1 seen, want 0");
    end
    run4(16'h1357, 16'h2468, 1'b1, 1'b0, s, lat);
    checks++;
    if (s !== 17'h037C0 || lat != 4) begin
      fails++;
      $display("FAIL rst_next: sum=%h lat=%0d, want 037c0 lat=4", s, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] q[$];
    logic [16:0] e;
    bit          acc;
    int          cyc = 0;
    int          last_t = -1;
    wait_idle();
`ifdef BK_SEQ_SUB_EN
    i4.sub = 1'b0;
`endif
    i4.a = 16'($urandom);
    i4.b = 16'($urandom);
    i4.cin = 1'($urandom);
    i4.in_valid  = 1'b1;
    i4.out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (k == 40) i4.in_valid = 1'b0;
      acc = i4.in_ready && i4.in_valid;
      tick();
      cyc++;
      if (acc) begin
        q.push_back(model(i4.a, i4.b, i4.cin, 1'b0));
        i4.a = 16'($urandom);
        i4.b = 16'($urandom);
        i4.cin = 1'($urandom);
      end
      if (i4.out_valid) begin
        e = (q.size() > 0) ? q.pop_front() : 17'h0;
        checks++;
        if (i4.sum !== e) begin
          fails++;
          $display("FAIL b2b_sum: sum=%h, want %h", i4.sum, e);
        end
        if (last_t >= 0) begin
          checks++;
          if (cyc - last_t != 6) begin
            fails++;
            $display("FAIL b2b_period: %0d cycles, want 6", cyc - last_t);
          end
        end
        last_t = cyc;
      end
    end
    checks++;
    if (q.size() != 0 || last_t < 0) begin
      fails++;
      $display("FAIL b2b_drain: %0d pending, last=%0d, want 0 pending", q.size(), last_t);
    end
    i4.out_ready = 1'b0;
  endtask

  task automatic test_n1_exhaustive();
    logic [8:0] v;
    logic [4:0] e;
    i1.out_ready = 1'b1;
    for (int n = 0; n < 512; n++) begin
      v = 9'(n);
      e = 5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]);
      checks++;
      if (i1.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL n1_ready%0d: rdy=%b, want 1", n, i1.in_ready);
      end
      i1.a = v[3:0];
      i1.b = v[7:4];
      i1.cin = v[8];
      i1.in_valid = 1'b1;
      tick();
      i1.in_valid = 1'b0;
      tick();
      checks++;
      if (i1.out_valid !== 1'b1 || i1.sum !== e) begin
        fails++;
        $display("FAIL n1_sum%0d: vld=%b sum=%h, want 1 %h", n, i1.out_valid, i1.sum, e);
      end
      tick();
    end
  endtask

`ifdef BK_SEQ_SUB_EN
  task automatic test_sub();
    logic [15:0] va [2] = '{16'h0005, 16'h0007};
    logic [15:0] vb [2] = '{16'h0007, 16'h0005};
    logic [16:0] ve [2] = '{17'h0FFFE, 17'h10002};
    logic [16:0] s;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run4(va[i%2], vb[i%2], 1'(i / 2), 1'b1, s, lat);
      checks++;
      if (s !== ve[i%2] || lat != 4) begin
        fails++;
        $display("FAIL sub%0d: sum=%h lat=%0d, want %h lat=4", i, s, lat, ve[i%2]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = 16'($urandom);
      run4(a, b, 1'($urandom), 1'b1, s, lat);
      checks++;
      if (s !== model(a, b, 1'b0, 1'b1)) begin
        fails++;
        $display("FAIL sub_rand%0d: %h-%h sum=%h, want %h", i, a, b, s, model(a, b, 1'b0, 1'b1));
      end
    end
  endtask
`endif

  initial begin
    i4.in_valid = 1'b0;
    i4.a = '0;
    i4.b = '0;
    i4.cin = 1'b0;
    i4.out_ready = 1'b0;
    i1.in_valid = 1'b0;
    i1.a = '0;
    i1.b = '0;
    i1.cin = 1'b0;
    i1.out_ready = 1'b0;
`ifdef BK_SEQ_SUB_EN
    i4.sub = 1'b0;
    i1.sub = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_n1_exhaustive();
`ifdef BK_SEQ_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/bk_nibble_sequencer.md
# bk_nibble_sequencer

- Adds wide operands (4·NIBBLES bits) using one shared 4-bit Brent-Kung adder (`Bruent`: A[3:0], B[3:0], Cin, Sum[4:0]).
- Processes one nibble per clock, least-significant first, and registers the carry between nibbles.
- Sits between a requester and a consumer, with valid/ready handshakes on both sides.
- Trades latency for area in wide-add paths.

## Interface
Parameters:
- NIBBLES, default 4: number of 4-bit slices. Operand width W = 4·NIBBLES. Legal range 1..16.

Ports:
- Clk, input, 1: rising-edge clock.
- Rst, input, 1: synchronous, active-high reset.
- In_valid, input, 1: request carries valid operands.
- In_ready, output, 1: block can accept a request.
- A, input, W: operand A.
- B, input, W: operand B.
- Cin, input, 1: carry-in to nibble 0.
- Out_valid, output, 1: Sum holds a completed result.
- Out_ready, input, 1: consumer accepts the result.
- Sum, output, W+1: result; MSB is the final carry-out.
- Busy, output, 1: high in RUN.

## Operation
- Exactly one `Bruent` instance is the only adder in the block. No `+` operator is used on the datapath.
- FSM states:
  - IDLE: In_ready=1.
    - In_valid=1 at an edge captures A, B and Cin into A_r, B_r and carry_r.
    - The same edge clears idx to 0 and moves the FSM to RUN.
  - RUN: In_ready=0, Busy=1.
    - Adder inputs: A=A_r[4·idx+:4], B=B_r[4·idx+:4], Cin=carry_r.
    - Each edge writes adder Sum[3:0] into result nibble idx and adder Sum[4] into carry_r, then increments idx.
    - At the edge where idx==NIBBLES-1: Sum[W-1:0] takes the result nibbles, Sum[W] takes the adder Sum[4], and the FSM moves to DONE.
  - DONE: Out_valid=1, In_ready=0.
    - Out_ready=1 at an edge moves the FSM to IDLE.
- In_valid is ignored outside IDLE. A, B and Cin are sampled only at the accept edge.
- Sum is held stable from entry to DONE until the next DONE entry. It is meaningful only while Out_valid=1.
- Result identity: Sum == A + B + Cin, computed at W+1 bits with no truncation.
- Rst is sampled every edge and has priority over all transitions.
  - Rst high forces IDLE from any state, including mid-RUN and DONE.
  - An in-flight operation is discarded; no Out_valid is produced for it.

## Timing
- Reset values: In_ready=1, Out_valid=0, Busy=0, Sum=0, idx=0, carry_r=0.
- In_ready, Out_valid and Busy are registered: decoded from the state register, with no input-to-output combinational path.
- Latency: a request accepted at edge k makes Out_valid=1 after edge k+NIBBLES.
  - NIBBLES=1: Out_valid after edge k+1.
- Back-to-back throughput: one result per NIBBLES+2 cycles.
  - DONE→IDLE costs one edge.
  - IDLE→RUN costs one edge.
  - In_ready does not rise in the same cycle as the output handshake.
- Backpressure: Out_ready low holds DONE indefinitely; Sum and Out_valid stay stable.
- idx counter width: clog2(NIBBLES), minimum 1 bit. It never wraps past NIBBLES-1 in RUN.

## Configuration
- Macro `BK_SEQ_SUB_EN`.
- Defined:
  - Adds input port Sub (1 bit), captured with the operands at the accept edge.
  - Sub=1 means the adder's B input is ~B_r nibble and the initial carry_r=1; Cin is ignored.
  - Sub=1 result: Sum = {1'b0,A} + {1'b0,~B} + 1. Sum[W]=1 means no borrow (A≥B unsigned).
  - Sub=0 behaves exactly as the undefined build.
- Undefined: no Sub port, and add-only behaviour as specified above.

## Test plan
- NIBBLES=4, A=16'hFFFF, B=16'h0001, Cin=0 → Out_valid exactly 4 edges after accept; Sum=17'h10000.
- NIBBLES=4, A=16'hFFFF, B=16'h0000, Cin=1 → Sum=17'h10000 (carry ripples through all nibbles). Then A=16'h1234, B=16'h4321, Cin=0 → Sum=17'h05555.
- Backpressure: hold Out_ready=0 for 5 cycles after Out_valid while driving In_valid=1 with new operands. Required: Sum stable, In_ready=0, and the new operands are accepted only after the handshake plus one edge.
- Reset mid-operation: assert Rst for one edge at RUN idx=2. Required: next cycle In_ready=1, Busy=0, Out_valid=0; no result for the aborted request; a subsequent request completes correctly.
- NIBBLES=1, exhaustive over all 512 {Cin,B,A} values with Out_ready=1. Required: every Sum == A+B+Cin, with latency 1 and a 3-cycle repeat.
- With `BK_SEQ_SUB_EN`:
  - NIBBLES=4, Sub=1, A=16'h0005, B=16'h0007 → Sum=17'h0FFFE.
  - A=16'h0007, B=16'h0005 → Sum=17'h10002.
  - Cin=1 has no effect in both cases.
